glitch_seq_wb: RTL and testbench

//  Wishbone-slave clock-glitch sequencer; successor to the single-shot glitcher. After an arm command, it waits for a

---
 rtl/glitch_seq_wb_pkg.sv | 31 +++
 rtl/glitch_seq.sv | 120 ++++++++++++
 rtl/glitch_seq_wb.sv | 124 ++++++++++++
 tb/tb_glitch_seq_wb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/glitch_seq_wb_pkg.sv
// Shared register map, CTRL bit positions, FSM encodings and status layout
// for the Wishbone glitch sequencer.
package glitch_seq_wb_pkg;

    localparam logic [3:0] ADR_CTRL   = 4'h0;
    localparam logic [3:0] ADR_WIDTH  = 4'h1;
    localparam logic [3:0] ADR_DELAY0 = 4'h2;
    localparam logic [3:0] ADR_GAP0   = 4'h6;
    localparam logic [3:0] ADR_COUNT  = 4'hA;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_EXT   = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_DELAY  = 3'd2;
    localparam logic [2:0] ST_GLITCH = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // CTRL read layout, LSB last: {ext_trig, done, busy, armed, ready}
    typedef struct packed {
        logic ext_trig;
        logic done;
        logic busy;
        logic armed;
        logic ready;
    } ctrl_status_t;

endpackage

// File: rtl/glitch_seq.sv
// Trigger synchroniser, sequencing FSM and counters; produces glitch_en and
// the glitched target clock.
module glitch_seq
    import glitch_seq_wb_pkg::*;
#(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic [DELAY_W-1:0] gap_i,
    input  logic [WIDTH_W-1:0] width_i,
    input  logic [COUNT_W-1:0] count_i,
    input  logic               ext_trig_i,
    input  logic               trig_i,
    input  logic               clk_in_i,
    output logic               ready_o,
    output logic               armed_o,
    output logic               delay_en_o,
    output logic               done_o,
    output logic               glitch_en_o,
    output logic               clk_out_o
);

    logic [2:0]         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d, delay_s_q, gap_s_q;
    logic [WIDTH_W-1:0] wcnt_q, wcnt_d, width_s_q;
    logic [COUNT_W-1:0] pcnt_q, pcnt_d;
    logic               ext_s_q, glitch_en_q, glitch_en_d;
    logic               sync1_q, sync2_q, prev_q;
    logic               trig_edge, take_arm;

    assign trig_edge = sync2_q & ~prev_q;
    assign take_arm  = arm_i & ~abort_i & (state_q == ST_IDLE);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            ST_IDLE: if (take_arm) begin
                state_d = ST_ARMED;
                pcnt_d  = (count_i == '0) ? COUNT_W'(1) : count_i;
            end
            ST_ARMED: if (!ext_s_q || trig_edge) begin
                state_d = ST_DELAY;
                cnt_d   = delay_s_q;
            end
            ST_DELAY, ST_GAP: if (cnt_q == '0) begin
                state_d = ST_GLITCH;
                wcnt_d  = width_s_q;
            end else begin
                cnt_d = cnt_q - DELAY_W'(1);
            end
            ST_GLITCH: if (wcnt_q <= WIDTH_W'(1)) begin
                if (pcnt_q > COUNT_W'(1)) begin
                    state_d = ST_GAP;
                    cnt_d   = gap_s_q;
                    pcnt_d  = pcnt_q - COUNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end else begin
                wcnt_d = wcnt_q - WIDTH_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    // A zero-width pulse still spends one cycle in GLITCH, but with glitch_en low.
    assign glitch_en_d = (state_d == ST_GLITCH) && (width_s_q != '0);

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            pcnt_q      <= '0;
            delay_s_q   <= '0;
            gap_s_q     <= '0;
            width_s_q   <= '0;
            ext_s_q     <= 1'b0;
            glitch_en_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            pcnt_q      <= pcnt_d;
            glitch_en_q <= glitch_en_d;
            sync1_q     <= trig_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            if (take_arm) begin
                delay_s_q <= delay_i;
                gap_s_q   <= gap_i;
                width_s_q <= width_i;
                ext_s_q   <= ext_trig_i;
            end
        end
    end

    assign ready_o     = (state_q == ST_IDLE);
    assign armed_o     = (state_q == ST_ARMED);
    assign delay_en_o  = (state_q == ST_DELAY) || (state_q == ST_GAP);
    assign done_o      = (state_q == ST_DONE);
    assign glitch_en_o = glitch_en_q;
    assign clk_out_o   = clk_in_i ^ glitch_en_q;

endmodule

// File: rtl/glitch_seq_wb.sv
// Wishbone slave front end for the glitch sequencer: bus decode, config
// registers, sticky done flag and debug channel wiring.
module glitch_seq_wb
    import glitch_seq_wb_pkg::*;
#(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int COUNT_W = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [3:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic       trig_in,
    input  logic       clk_in,
    output logic [5:0] ch_out
);

    logic               ack_q;
    logic [7:0]         dat_q, rdata;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [DELAY_W-1:0] delay_q, delay_d, gap_q, gap_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ext_q, ext_d, done_q, done_d;
    logic               access, wr, ctrl_wr, arm, abort;
    logic               ready, armed, delay_en, seq_done, glitch_en, clk_out;
    ctrl_status_t       status;

    assign access  = stb_i & ~ack_q;
    assign wr      = access & we_i;
    assign ctrl_wr = wr & (adr_i == ADR_CTRL);
    assign arm     = ctrl_wr & dat_i[CTRL_ARM];
    assign abort   = ctrl_wr & dat_i[CTRL_ABORT];
    assign status  = '{ext_trig: ext_q, done: done_q, busy: ~ready, armed: armed, ready: ready};

    always_comb begin
        width_d = width_q;
        delay_d = delay_q;
        gap_d   = gap_q;
        count_d = count_q;
        ext_d   = ext_q;
        done_d  = done_q;
        rdata   = '0;
        // Configuration is frozen while a sequence is running
        if (wr && ready) begin
            if (adr_i == ADR_CTRL)  ext_d   = dat_i[CTRL_EXT];
            if (adr_i == ADR_WIDTH) width_d = WIDTH_W'(dat_i);
            if (adr_i == ADR_COUNT) count_d = dat_i[COUNT_W-1:0];
            for (int b = 0; b < DELAY_W / 8; b++) begin
                if (adr_i == 4'(ADR_DELAY0 + b)) delay_d[8*b +: 8] = dat_i;
                if (adr_i == 4'(ADR_GAP0 + b))   gap_d[8*b +: 8]   = dat_i;
            end
        end
        case (adr_i)
            ADR_CTRL:  rdata = 8'(status);
            ADR_WIDTH: rdata = 8'(width_q);
            ADR_COUNT: rdata = 8'(count_q);
            default: begin
                for (int b = 0; b < DELAY_W / 8; b++) begin
                    if (adr_i == 4'(ADR_DELAY0 + b)) rdata = delay_q[8*b +: 8];
                    if (adr_i == 4'(ADR_GAP0 + b))   rdata = gap_q[8*b +: 8];
                end
            end
        endcase
        if (seq_done)                     done_d = 1'b1;
        else if (arm && ready && !abort)  done_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            width_q <= '0;
            delay_q <= '0;
            gap_q   <= '0;
            count_q <= '0;
            ext_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ack_q <= access;
            if (access && !we_i) dat_q <= rdata;
            width_q <= width_d;
            delay_q <= delay_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            ext_q   <= ext_d;
            done_q  <= done_d;
        end
    end

    // ext_d lets an arm write that also sets ext_trig take effect in one access
    glitch_seq #(
        .DELAY_W (DELAY_W),
        .WIDTH_W (WIDTH_W),
        .COUNT_W (COUNT_W)
    ) u_seq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .arm_i       (arm),
        .abort_i     (abort),
        .delay_i     (delay_q),
        .gap_i       (gap_q),
        .width_i     (width_q),
        .count_i     (count_q),
        .ext_trig_i  (ext_d),
        .trig_i      (trig_in),
        .clk_in_i    (clk_in),
        .ready_o     (ready),
        .armed_o     (armed),
        .delay_en_o  (delay_en),
        .done_o      (seq_done),
        .glitch_en_o (glitch_en),
        .clk_out_o   (clk_out)
    );

    assign ack_o  = ack_q;
    assign dat_o  = dat_q;
    assign ch_out = {delay_en, glitch_en, ready, armed, clk_in, clk_out};

endmodule

// File: tb/tb_glitch_seq_wb.sv
// Scoreboard bench for glitch_seq_wb: bus reads and per-cycle sequence
// patterns are queued at stimulus time and compared as the DUT responds.
module tb_glitch_seq_wb;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       stb_i   = 1'b0;
    logic       we_i    = 1'b0;
    logic [3:0] adr_i   = 4'h0;
    logic [7:0] dat_i   = 8'h00;
    logic       trig_in = 1'b0;
    logic       clk_in  = 1'b0;
    logic [7:0] dat_o;
    logic       ack_o;
    logic [5:0] ch_out;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rd_q[$];
    logic [3:0] seq_q[$];
    logic [5:0] ch_at_ack;
    logic       glitch_seen;

    glitch_seq_wb dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .trig_in (trig_in),
        .clk_in  (clk_in),
        .ch_out  (ch_out)
    );

    always #5 clk_i = ~clk_i;

    // Target clock toggles mid-cycle so it is stable when sampled at negedge
    always @(posedge clk_i) begin
        #3;
        clk_in = ~clk_in;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [7:0] dat);
        logic [7:0] want;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = adr;
        dat_i = dat;
        @(posedge clk_i); #1;
        ch_at_ack = ch_out;
        check("ack_lat", 32'(ack_o), 1);
        if (!we && rd_q.size() > 0) begin
            want = rd_q.pop_front();
            check($sformatf("rd_%0h", adr), 32'(dat_o), 32'(want));
        end
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(posedge clk_i); #1;
        check("ack_once", 32'(ack_o), 0);
    endtask

    task automatic bus_write(input logic [3:0] adr, input logic [7:0] dat);
        bus_xfer(1'b1, adr, dat);
    endtask

    task automatic bus_read(input logic [3:0] adr, input logic [7:0] want);
        rd_q.push_back(want);
        bus_xfer(1'b0, adr, 8'h00);
    endtask

    task automatic cfg(input int d, input int w, input int g, input int c);
        bus_write(4'h1, 8'(w));
        bus_write(4'h2, 8'(d));
        bus_write(4'h3, 8'(d >> 8));
        bus_write(4'h6, 8'(g));
        bus_write(4'h7, 8'(g >> 8));
        bus_write(4'hA, 8'(c));
    endtask

    // Expected {delay_en, glitch_en, ready, armed} for each cycle after DELAY entry
    task automatic push_seq(input int d, input int w, input int g, input int c);
        int n;
        n = (c == 0) ? 1 : c;
        repeat (d + 1) seq_q.push_back(4'b1000);
        for (int p = 0; p < n; p++) begin
            if (w == 0) seq_q.push_back(4'b0000);
            else repeat (w) seq_q.push_back(4'b0100);
            if (p < n - 1) repeat (g + 1) seq_q.push_back(4'b1000);
        end
        seq_q.push_back(4'b0000);
        seq_q.push_back(4'b0010);
    endtask

    task automatic run_seq(input string tag);
        logic [3:0] e;
        while (seq_q.size() > 0) begin
            @(negedge clk_i);
            e = seq_q.pop_front();
            check(tag, 32'(ch_out[5:2]), 32'(e));
            check({tag, "_clk"}, 32'(ch_out[0]), 32'(clk_in ^ e[2]));
        end
    endtask

    task automatic arm_run(input int d, input int w, input int g, input int c, input string tag);
        cfg(d, w, g, c);
        push_seq(d, w, g, c);
        bus_write(4'h0, 8'h01);
        run_seq(tag);
    endtask

    task automatic wait_ch(input int idx, input logic val, input int budget, input string tag);
        int n;
        n = 0;
        while (ch_out[idx] !== val && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, 32'(ch_out[idx]), 32'(val));
    endtask

    initial begin
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack", 32'(ack_o), 0);
        check("rst_dat", 32'(dat_o), 0);
        check("rst_ch", 32'(ch_out[5:2]), 32'(4'b0010));
        check("rst_clk", 32'(ch_out[0]), 32'(clk_in));
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int a = 0; a < 16; a++) bus_read(4'(a), (a == 0) ? 8'h01 : 8'h00);

        bus_write(4'h4, 8'hFF);  bus_read(4'h4, 8'h00);
        bus_write(4'h9, 8'hFF);  bus_read(4'h9, 8'h00);
        bus_write(4'hA, 8'hFF);  bus_read(4'hA, 8'h0F);
        bus_write(4'h3, 8'hAB);  bus_read(4'h3, 8'hAB);
        bus_write(4'hF, 8'h5A);  bus_read(4'hF, 8'h00);

        arm_run(5, 3, 0, 1, "seq_a");
        bus_read(4'h0, 8'h09);
        bus_write(4'h0, 8'h02);
        bus_read(4'h0, 8'h09);

        arm_run(0, 2, 4, 3, "seq_b");
        arm_run(1, 0, 1, 2, "seq_w0");
        arm_run(0, 1, 0, 0, "seq_c0");

        cfg(0, 2, 4, 3);
        bus_write(4'h0, 8'h05);
        glitch_seen = 1'b0;
        repeat (50) begin
            @(negedge clk_i);
            if (ch_out[4]) glitch_seen = 1'b1;
        end
        check("ext_no_glitch", 32'(glitch_seen), 0);
        check("ext_armed", 32'(ch_out[2]), 1);
        bus_read(4'h0, 8'h16);
        trig_in = 1'b1;
        @(posedge clk_i); @(posedge clk_i); #1;
        check("trig_lat2", 32'(ch_out[5]), 0);
        @(posedge clk_i); #1;
        check("trig_lat3", 32'(ch_out[5]), 1);
        wait_ch(3, 1'b1, 100, "ext_done");
        trig_in = 1'b0;
        bus_read(4'h0, 8'h19);
        bus_write(4'h0, 8'h00);

        cfg(200, 3, 0, 1);
        bus_write(4'h0, 8'h01);
        bus_write(4'h1, 8'h55);
        bus_read(4'h1, 8'h03);
        bus_read(4'h2, 8'hC8);
        bus_write(4'h0, 8'h02);
        check("busy_abort_ready", 32'(ch_at_ack[3]), 1);

        cfg(0, 10, 0, 1);
        bus_write(4'h0, 8'h01);
        wait_ch(4, 1'b1, 50, "abort_wait_glitch");
        bus_write(4'h0, 8'h02);
        check("abort_glitch", 32'(ch_at_ack[4]), 0);
        check("abort_ready", 32'(ch_at_ack[3]), 1);
        bus_read(4'h0, 8'h01);

        cfg(0, 2, 20, 3);
        bus_write(4'h0, 8'h01);
        wait_ch(4, 1'b1, 50, "rst_wait_glitch");
        wait_ch(5, 1'b1, 50, "rst_wait_gap");
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        check("midrst_ack", 32'(ack_o), 0);
        check("midrst_dat", 32'(dat_o), 0);
        check("midrst_ch", 32'(ch_out[5:2]), 32'(4'b0010));
        check("midrst_clk", 32'(ch_out[0]), 32'(clk_in));
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        bus_read(4'h1, 8'h00);
        bus_read(4'h6, 8'h00);
        bus_read(4'h0, 8'h01);

        bus_write(4'h0, 8'h03);
        check("armabort_ready", 32'(ch_at_ack[3]), 1);
        check("armabort_armed", 32'(ch_at_ack[2]), 0);
        repeat (3) @(negedge clk_i);
        check("armabort_idle", 32'(ch_out[3]), 1);
        bus_read(4'h0, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
